// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: glyph table, blank pattern, widths.
package seg7_pkg;

    localparam int SEG_W  = 7;
    localparam int DIGITS = 4;
    localparam int NIB_W  = 4;

    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

    // Active-low glyphs indexed by the hex value they display.
    localparam logic [SEG_W-1:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_capture_if.sv
// Bus bundle between the NIOS-side host (master) and the segment capture peripheral (slave).
interface seg7_capture_if;
    import seg7_pkg::*;

    logic [SEG_W-1:0]         iSEG0;
    logic [SEG_W-1:0]         iSEG1;
    logic [SEG_W-1:0]         iSEG2;
    logic [SEG_W-1:0]         iSEG3;
    logic                     iRD;
    logic [DIGITS*NIB_W-1:0]  oDIG;
    logic [DIGITS-1:0]        oVLD;
    logic                     oCHG;
    logic                     oERR;

    modport master (
        output iSEG0, iSEG1, iSEG2, iSEG3, iRD,
        input  oDIG, oVLD, oCHG, oERR
    );

    modport slave (
        input  iSEG0, iSEG1, iSEG2, iSEG3, iRD,
        output oDIG, oVLD, oCHG, oERR
    );

endinterface

// File: rtl/seg7_glyph_dec.sv
// Combinational decode of one active-low segment pattern to {nibble, valid, err}.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [NIB_W-1:0] nibble,
    output logic             valid,
    output logic             err
);

    always_comb begin
        nibble = '0;
        valid  = 1'b0;
        err    = (seg != SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH[i]) begin
                nibble = i[NIB_W-1:0];
                valid  = 1'b1;
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples four segment buses, commits stable patterns as decoded nibbles and keeps sticky flags.
// Optional stability filter enabled by defining SEG7_CAPTURE_FILTER_EN.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    seg7_capture_if.slave bus
);

    localparam int RAW_W = DIGITS * SEG_W;
    localparam int DIG_W = DIGITS * NIB_W;

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : gBadParam
        $error("seg7_capture: STABLE_CYCLES must be within 2..255");
    end

    logic [RAW_W-1:0]  segIn;
    logic [RAW_W-1:0]  s1Reg;
    logic [RAW_W-1:0]  rawReg;
    logic [DIG_W-1:0]  digReg;
    logic [DIGITS-1:0] vldReg;
    logic              chgReg, chgNext;
    logic              errReg, errNext;

    logic [DIG_W-1:0]  decDig;
    logic [DIGITS-1:0] decVld;
    logic [DIGITS-1:0] decErr;
    logic              stable;
    logic              commit;
    logic              changed;

    assign segIn = {bus.iSEG3, bus.iSEG2, bus.iSEG1, bus.iSEG0};

    for (genvar gi = 0; gi < DIGITS; gi++) begin : gDec
        seg7_glyph_dec uDec (
            .seg    (s1Reg[gi*SEG_W +: SEG_W]),
            .nibble (decDig[gi*NIB_W +: NIB_W]),
            .valid  (decVld[gi]),
            .err    (decErr[gi])
        );
    end

`ifdef SEG7_CAPTURE_FILTER_EN
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [7:0] cntReg, cntNext;

    // Count restarts on any difference against the previous sample and saturates at CNT_MAX.
    always_comb begin
        cntNext = cntReg;
        if (segIn != s1Reg) begin
            cntNext = '0;
        end else if (cntReg != CNT_MAX) begin
            cntNext = cntReg + 8'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cntReg <= '0;
        end else begin
            cntReg <= cntNext;
        end
    end

    assign stable = (cntReg == CNT_MAX);
`else
    assign stable = 1'b1;
`endif

    assign commit  = stable && (s1Reg != rawReg);
    assign changed = ({decDig, decVld} != {digReg, vldReg});

    // A commit that sets a flag overrides a coincident read acknowledge.
    always_comb begin
        chgNext = chgReg;
        errNext = errReg;
        if (bus.iRD) begin
            chgNext = 1'b0;
            errNext = 1'b0;
        end
        if (commit && changed) begin
            chgNext = 1'b1;
        end
        if (commit && (decErr != '0)) begin
            errNext = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1Reg  <= {DIGITS{SEG7_BLANK}};
            rawReg <= {DIGITS{SEG7_BLANK}};
            digReg <= '0;
            vldReg <= '0;
            chgReg <= 1'b0;
            errReg <= 1'b0;
        end else begin
            s1Reg  <= segIn;
            chgReg <= chgNext;
            errReg <= errNext;
            if (commit) begin
                rawReg <= s1Reg;
                digReg <= decDig;
                vldReg <= decVld;
            end
        end
    end

    assign bus.oDIG = digReg;
    assign bus.oVLD = vldReg;
    assign bus.oCHG = chgReg;
    assign bus.oERR = errReg;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed and randomized checks of seg7_capture against a "held-for-N-samples" reference model.
module tb_seg7_capture;

    localparam int STABLE = 4;
`ifdef SEG7_CAPTURE_FILTER_EN
    localparam int THR = STABLE;
`else
    localparam int THR = 1;
`endif

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int nVec  = 0;
    int nFail = 0;

    // Reference state: last sample, how many consecutive edges it has been seen, committed view.
    logic [27:0] mS1;
    int          mRun;
    logic [27:0] mRaw;
    logic [15:0] mDig;
    logic [3:0]  mVld;
    logic        mChg;
    logic        mErr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [27:0] v, output logic [15:0] d,
                                   output logic [3:0] vl, output logic e);
        d = '0; vl = '0; e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [6:0] p;
            logic       ok;
            p  = v[i*7 +: 7];
            ok = 1'b0;
            for (int g = 0; g < 16; g++) begin
                if (p == GLYPHS[g]) begin
                    d[i*4 +: 4] = 4'(g);
                    ok = 1'b1;
                end
            end
            vl[i] = ok;
            if (!ok && p != 7'h7F) e = 1'b1;
        end
    endfunction

    task automatic modelEdge(input logic [27:0] vin, input logic rd, input logic r);
        logic [15:0] nd;
        logic [3:0]  nv;
        logic        ne;
        if (r) begin
            mS1 = {4{7'h7F}}; mRun = 1; mRaw = {4{7'h7F}};
            mDig = '0; mVld = '0; mChg = 1'b0; mErr = 1'b0;
        end else begin
            if (rd) begin
                mChg = 1'b0;
                mErr = 1'b0;
            end
            if (mRun >= THR && mS1 != mRaw) begin
                decode(mS1, nd, nv, ne);
                if ({nd, nv} != {mDig, mVld}) mChg = 1'b1;
                if (ne) mErr = 1'b1;
                mRaw = mS1; mDig = nd; mVld = nv;
            end
            if (vin == mS1) mRun = (mRun < 1000) ? mRun + 1 : mRun;
            else            mRun = 1;
            mS1 = vin;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge({bus.iSEG3, bus.iSEG2, bus.iSEG1, bus.iSEG0}, bus.iRD, rst);
        #1;
        chk("model_dig", 32'(bus.oDIG), 32'(mDig));
        chk("model_vld", 32'(bus.oVLD), 32'(mVld));
        chk("model_chg", 32'(bus.oCHG), 32'(mChg));
        chk("model_err", 32'(bus.oERR), 32'(mErr));
    endtask

    task automatic setSegs(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
        bus.iSEG3 = s3; bus.iSEG2 = s2; bus.iSEG1 = s1; bus.iSEG0 = s0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [6:0] randPat();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16)      return GLYPHS[r];
        else if (r < 18) return 7'h7F;
        else             return 7'($urandom);
    endfunction

    initial begin
        setSegs(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        bus.iRD = 1'b0;
        rst = 1'b1;

        // Reset and idle blank inputs.
        tick();
        rst = 1'b0;
        ticks(20);
        chk("reset_dig", 32'(bus.oDIG), 32'h0);
        chk("reset_vld", 32'(bus.oVLD), 32'h0);
        chk("reset_chg", 32'(bus.oCHG), 32'h0);
        chk("reset_err", 32'(bus.oERR), 32'h0);

        // First commit of 4,6,2,0 and its latency.
        setSegs(7'h19, 7'h02, 7'h24, 7'h40);
        ticks(THR);
        chk("commit_early_chg", 32'(bus.oCHG), 32'h0);
        tick();
        chk("commit_dig", 32'(bus.oDIG), 32'h4620);
        chk("commit_vld", 32'(bus.oVLD), 32'hF);
        chk("commit_chg", 32'(bus.oCHG), 32'h1);
        bus.iRD = 1'b1;
        tick();
        bus.iRD = 1'b0;
        chk("rd_clr_chg", 32'(bus.oCHG), 32'h0);
        chk("rd_keep_dig", 32'(bus.oDIG), 32'h4620);

        // Three-cycle glitch on digit 0, then a genuine change to 1.
        bus.iSEG0 = 7'h79;
        ticks(3);
        bus.iSEG0 = 7'h40;
        ticks(THR + 2);
`ifdef SEG7_CAPTURE_FILTER_EN
        chk("glitch_no_chg", 32'(bus.oCHG), 32'h0);
        chk("glitch_dig", 32'(bus.oDIG), 32'h4620);
`endif
        bus.iRD = 1'b1;
        tick();
        bus.iRD = 1'b0;
        bus.iSEG0 = 7'h79;
        ticks(THR + 1);
        chk("d0_one_dig", 32'(bus.oDIG[3:0]), 32'h1);
        chk("d0_one_chg", 32'(bus.oCHG), 32'h1);

        // Undecodable digit 2, then a second bad pattern committed alongside iRD.
        bus.iSEG2 = 7'h55;
        ticks(THR + 1);
        chk("bad_vld", 32'(bus.oVLD), 32'hB);
        chk("bad_dig", 32'(bus.oDIG), 32'h4021);
        chk("bad_err", 32'(bus.oERR), 32'h1);
        bus.iRD = 1'b1;
        tick();
        bus.iRD = 1'b0;
        chk("bad_rd_err", 32'(bus.oERR), 32'h0);
        bus.iSEG2 = 7'h2A;
        ticks(THR);
        bus.iRD = 1'b1;
        tick();
        bus.iRD = 1'b0;
        chk("rd_vs_commit_err", 32'(bus.oERR), 32'h1);
        chk("same_decode_chg", 32'(bus.oCHG), 32'h0);

        // Reset in the middle of filtering, then full re-qualification.
        bus.iSEG1 = 7'h12;
        ticks(3);
        rst = 1'b1;
        tick();
        chk("midrst_dig", 32'(bus.oDIG), 32'h0);
        chk("midrst_flags", 32'({bus.oVLD, bus.oCHG, bus.oERR}), 32'h0);
        rst = 1'b0;
        ticks(THR);
        chk("postrst_wait_dig", 32'(bus.oDIG), 32'h0);
        tick();
        chk("postrst_dig", 32'(bus.oDIG), 32'h4051);
        chk("postrst_vld", 32'(bus.oVLD), 32'hB);

`ifndef SEG7_CAPTURE_FILTER_EN
        // Without the filter a one-cycle glitch is captured and then undone.
        bus.iSEG0 = 7'h40;
        ticks(4);
        bus.iSEG0 = 7'h00;
        tick();
        bus.iSEG0 = 7'h40;
        tick();
        chk("nofilt_glitch_dig", 32'(bus.oDIG[3:0]), 32'h8);
        tick();
        chk("nofilt_restore_dig", 32'(bus.oDIG[3:0]), 32'h0);
`endif

        // Randomized patterns with random hold lengths, acknowledges and resets.
        for (int n = 0; n < 120; n++) begin
            int hold;
            hold = $urandom_range(1, 7);
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 2) == 0) begin
                    case (d)
                        0: bus.iSEG0 = randPat();
                        1: bus.iSEG1 = randPat();
                        2: bus.iSEG2 = randPat();
                        default: bus.iSEG3 = randPat();
                    endcase
                end
            end
            for (int h = 0; h < hold; h++) begin
                bus.iRD = ($urandom_range(0, 4) == 0);
                rst     = ($urandom_range(0, 60) == 0);
                tick();
            end
            bus.iRD = 1'b0;
            rst     = 1'b0;
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
